// File: rtl/vibrometer_pkg.sv
// Shared types and GPIO field map for the vibrometer streaming chain.
package vibrometer_pkg;

  typedef struct packed {
    logic signed [15:0] im, re;
  } complex16_t;

  // GPIO field positions shared with the FFT and averager stages.
  localparam int unsigned ENABLE_BIT   = 0;
  localparam int unsigned LOG_AVG_LSB  = 1;
  localparam int unsigned LOG_THR_LSB  = 6;
  localparam int unsigned GPIO_FIELD_W = 5;

  // Frame counter is wide enough for any 5-bit log throttle.
  localparam int unsigned FRAME_CNT_W = 31;

  // Low `thr` bits set; a frame passes when these bits of the frame count are zero.
  function automatic logic [FRAME_CNT_W-1:0] thr_mask(input logic [GPIO_FIELD_W-1:0] thr);
    return ~({FRAME_CNT_W{1'b1}} << thr);
  endfunction

endpackage

// File: rtl/complex_mag_sq.sv
// Two-stage pipelined re^2 + im^2 with a global clock enable and valid/last passthrough.
module complex_mag_sq
  import vibrometer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] bin,
  input  logic        bin_valid,
  input  logic        bin_last,
  output logic [31:0] power,
  output logic        power_valid,
  output logic        power_last
);

  complex16_t  c;
  logic [31:0] re_ext, im_ext;
  logic [31:0] re_sq_q, im_sq_q;
  logic        valid1_q, last1_q;

  assign c      = bin;
  // Sign-extend so the low 32 bits of the product are the exact square (at most 2^30).
  assign re_ext = {{16{c.re[15]}}, c.re};
  assign im_ext = {{16{c.im[15]}}, c.im};

  // Stage 1: square both components.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sq_q  <= '0;
      im_sq_q  <= '0;
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (ce) begin
      re_sq_q  <= re_ext * re_ext;
      im_sq_q  <= im_ext * im_ext;
      valid1_q <= bin_valid;
      last1_q  <= bin_last;
    end
  end

  // Stage 2: sum into the output register; the sum is at most 2^31 so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power       <= '0;
      power_valid <= 1'b0;
      power_last  <= 1'b0;
    end else if (ce) begin
      power       <= re_sq_q + im_sq_q;
      power_valid <= valid1_q;
      power_last  <= last1_q;
    end
  end

endmodule

// File: rtl/axis_power_spectrum.sv
// Per-bin power of an FFT bin stream, framed with tlast and decimated by whole spectra.
module axis_power_spectrum
  import vibrometer_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH_IN  = 32,
  parameter int unsigned AXIS_TDATA_WIDTH_OUT = 32,
  parameter int unsigned LOG_FFT_LENGTH       = 8
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            enable,
  input  logic [GPIO_FIELD_W-1:0]         log_throttle,
  input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
  output logic                            M_AXIS_tvalid,
  output logic                            M_AXIS_tlast,
  input  logic                            M_AXIS_tready
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q;
  logic [LOG_FFT_LENGTH-1:0] bin_cnt_q;
  logic [FRAME_CNT_W-1:0]    frame_cnt_q;
  logic [GPIO_FIELD_W-1:0]   thr_q;
  logic                      ce, accept, frame_start, bin_last, pass;

  // Global stall: every stage moves together, so bubbles never hold up the input.
  assign ce            = ~M_AXIS_tvalid | M_AXIS_tready;
  assign S_AXIS_tready = ce & ~areset;
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;
  assign frame_start   = accept & (bin_cnt_q == '0);
  assign bin_last      = &bin_cnt_q;

  // Frame gate: bin 0 uses the live GPIO values, later bins use the copy latched at bin 0.
  always_comb begin
    pass = 1'b0;
    if (frame_start) begin
      pass = enable & ((frame_cnt_q & thr_mask(log_throttle)) == '0);
    end else begin
      pass = (state_q == StRun) & ((frame_cnt_q & thr_mask(thr_q)) == '0);
    end
  end

  // Bin and frame counters run on every accepted beat, emitted or not, to keep alignment.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else if (accept) begin
      bin_cnt_q <= bin_cnt_q + LOG_FFT_LENGTH'(1);
      if (bin_last) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  // Frame-level FSM: enable and throttle are only sampled at a frame start.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      thr_q   <= '0;
    end else if (frame_start) begin
      thr_q <= log_throttle;
      case (state_q)
        StIdle: if (enable)  state_q <= StRun;
        StRun:  if (!enable) state_q <= StIdle;
      endcase
    end
  end

  complex_mag_sq u_mag_sq (
    .clk         (aclk),
    .rst         (areset),
    .ce          (ce),
    .bin         (S_AXIS_tdata),
    .bin_valid   (accept & pass),
    .bin_last    (bin_last),
    .power       (M_AXIS_tdata),
    .power_valid (M_AXIS_tvalid),
    .power_last  (M_AXIS_tlast)
  );

endmodule

// File: tb/tb_axis_power_spectrum.sv
// Randomized bench for axis_power_spectrum with a frame-level reference model.
module tb_axis_power_spectrum;

  localparam int unsigned LogN = 3;
  localparam int unsigned N    = 1 << LogN;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic [4:0]  log_throttle;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;

  axis_power_spectrum #(
    .AXIS_TDATA_WIDTH_IN  (32),
    .AXIS_TDATA_WIDTH_OUT (32),
    .LOG_FFT_LENGTH       (LogN)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .log_throttle  (log_throttle),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tlast  (m_tlast),
    .M_AXIS_tready (m_tready)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  int          out_beats = 0;
  int          out_lasts = 0;
  bit          bp_mode   = 0;
  bit          lat_chk   = 0;

  // Reference model state: position in the spectrum and whether the current frame is emitted.
  int          m_bin     = 0;
  longint      m_frame   = 0;
  bit          m_emit    = 0;

  bit          prev_stall = 0;
  bit          prev_rst   = 1;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Output back-pressure source.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    exp_t   e;
    longint re, im;
    forever begin
      @(negedge aclk);
      if (areset) begin
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        exp_q.delete();
        m_bin      = 0;
        m_frame    = 0;
        m_emit     = 0;
        prev_stall = 0;
      end else begin
        if (prev_rst) check("rst_release_tready", s_tready, 1);
        check("tready_eq_ce", s_tready, !m_tvalid || m_tready);
        if (prev_stall) begin
          check("hold_tvalid", m_tvalid, 1);
          check("hold_tdata", m_tdata, prev_data);
          check("hold_tlast", m_tlast, prev_last);
        end
        if (m_tvalid && m_tready) begin
          out_beats++;
          if (m_tlast) out_lasts++;
          if (exp_q.size() == 0) begin
            check("spurious_beat", m_tvalid, 0);
          end else begin
            e = exp_q.pop_front();
            check("tdata", m_tdata, e.data);
            check("tlast", m_tlast, e.last);
            if (lat_chk) check("latency", cyc - e.cyc, 2);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (s_tvalid && s_tready) begin
          if (m_bin == 0) begin
            m_emit = enable && ((m_frame % (64'd1 << log_throttle)) == 0);
          end
          re = longint'($signed(s_tdata[15:0]));
          im = longint'($signed(s_tdata[31:16]));
          if (m_emit) begin
            e.data = 32'(re * re + im * im);
            e.last = (m_bin == N - 1);
            e.cyc  = cyc;
            exp_q.push_back(e);
          end
          m_bin++;
          if (m_bin == N) begin
            m_bin = 0;
            m_frame++;
          end
        end
      end
      prev_rst = areset;
      cyc++;
    end
  end

  task automatic do_reset(input int n);
    areset   = 1'b1;
    s_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] re, input logic [15:0] im);
    int n   = 0;
    bit acc = 0;
    s_tdata  = {im, re};
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", acc, 1);
    s_tvalid = 1'b0;
  endtask

  // One spectrum of random bins; enable/throttle are changed just before bin chg_bin.
  task automatic send_frame(input int chg_bin, input bit chg_en, input logic [4:0] chg_thr);
    for (int b = 0; b < int'(N); b++) begin
      if (b == chg_bin) begin
        enable       = chg_en;
        log_throttle = chg_thr;
      end
      send_beat(rand16(), rand16());
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int base_b, base_l;
    areset       = 1'b1;
    enable       = 1'b0;
    log_throttle = '0;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    do_reset(3);

    // Arithmetic corners plus one full random frame, no back-pressure, latency checked.
    enable       = 1'b1;
    log_throttle = 5'd0;
    lat_chk      = 1'b1;
    base_b       = out_beats;
    base_l       = out_lasts;
    send_beat(16'd3, 16'd4);
    send_beat(16'h8000, 16'h8000);
    send_beat(16'h7fff, 16'hffff);
    send_beat(16'd0, 16'd0);
    send_beat(16'd1, 16'd1);
    for (int i = 0; i < 3; i++) send_beat(rand16(), rand16());
    send_frame(-1, 1'b1, 5'd0);
    drain();
    lat_chk = 1'b0;
    check("arith_beats", out_beats - base_b, 2 * N);
    check("arith_lasts", out_lasts - base_l, 2);

    // Throttle by 4 over 8 back-to-back spectra.
    do_reset(2);
    enable       = 1'b1;
    log_throttle = 5'd2;
    base_b       = out_beats;
    base_l       = out_lasts;
    for (int f = 0; f < 8; f++) send_frame(-1, 1'b1, 5'd2);
    drain();
    check("thr_beats", out_beats - base_b, 2 * N);
    check("thr_lasts", out_lasts - base_l, 2);

    // Enable raised mid frame 0, dropped mid frame 1.
    do_reset(2);
    enable       = 1'b0;
    log_throttle = 5'd0;
    base_b       = out_beats;
    base_l       = out_lasts;
    send_frame(3, 1'b1, 5'd0);
    send_frame(5, 1'b0, 5'd0);
    send_frame(-1, 1'b0, 5'd0);
    drain();
    check("en_beats", out_beats - base_b, N);
    check("en_lasts", out_lasts - base_l, 1);

    // Random back-pressure over 4 spectra.
    do_reset(2);
    enable       = 1'b1;
    log_throttle = 5'd0;
    bp_mode      = 1'b1;
    base_b       = out_beats;
    base_l       = out_lasts;
    for (int f = 0; f < 4; f++) send_frame(-1, 1'b1, 5'd0);
    drain();
    check("bp_beats", out_beats - base_b, 4 * N);
    check("bp_lasts", out_lasts - base_l, 4);

    // Random enable/throttle changes at random bins under back-pressure.
    do_reset(2);
    for (int f = 0; f < 6; f++) begin
      send_frame(int'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 2)));
    end
    drain();
    bp_mode = 1'b0;

    // Reset at bin 5 with beats in flight, then a fresh spectrum.
    do_reset(2);
    enable       = 1'b1;
    log_throttle = 5'd0;
    for (int b = 0; b < 5; b++) send_beat(rand16(), rand16());
    do_reset(2);
    base_b = out_beats;
    base_l = out_lasts;
    send_beat(16'd7, 16'd0);
    for (int b = 1; b < int'(N); b++) send_beat(rand16(), rand16());
    drain();
    check("post_rst_beats", out_beats - base_b, N);
    check("post_rst_lasts", out_lasts - base_l, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
